// File: rtl/fifo_sync.sv
// Single-clock FIFO with chip select, registered read data and full/empty flags.
// Optional sticky overflow/underflow outputs are enabled by defining FIFO_SYNC_ERR_FLAGS_EN.
module fifo_sync #(
  parameter int FIFO_DEPTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH_LOG = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
`ifdef FIFO_SYNC_ERR_FLAGS_EN
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
`else
  output logic                  full
`endif
);

  localparam int PW = FIFO_DEPTH_LOG + 1;
  localparam logic [PW-1:0] PTR_ONE = {{FIFO_DEPTH_LOG{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  wr_ok, rd_ok;

  // The extra pointer MSB distinguishes a full buffer from an empty one.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_DEPTH_LOG-1:0] == rd_ptr_q[FIFO_DEPTH_LOG-1:0]) &&
                 (wr_ptr_q[FIFO_DEPTH_LOG] != rd_ptr_q[FIFO_DEPTH_LOG]);

  assign data_out = data_out_q;

  always_comb begin
    wr_ok      = cs && wr_en && !full;
    rd_ok      = cs && rd_en && !empty;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_ok) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = mem_q[rd_ptr_q[FIFO_DEPTH_LOG-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage is not reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q[FIFO_DEPTH_LOG-1:0]] <= data_in;
    end
  end

`ifdef FIFO_SYNC_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  || (cs && wr_en && full);
    underflow_d = underflow_q || (cs && rd_en && empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_fifo_sync;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic        cs;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        empty;
  logic        full;
`ifdef FIFO_SYNC_ERR_FLAGS_EN
  logic        overflow;
  logic        underflow;
`endif

  fifo_sync #(.FIFO_DEPTH(8), .DATA_WIDTH(32), .FIFO_DEPTH_LOG(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (cs),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .data_out (data_out),
    .empty    (empty),
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    .full     (full),
    .overflow (overflow),
    .underflow(underflow)
`else
    .full     (full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int txn    = 0;

  // Reference model: a plain queue of stored words plus the last read value.
  logic [31:0] model_q[$];
  logic [31:0] m_dout;
  logic        m_ovf;
  logic        m_udf;

  typedef struct {
    logic        cs;
    logic        wr;
    logic        rd;
    logic [31:0] din;
    logic [31:0] dout;
    logic        empty;
    logic        full;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (txn %0d)", name, act, exp, txn);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    m_dout = 32'd0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic check_model();
    check("data_out", data_out, m_dout);
    check("empty", {31'd0, empty}, {31'd0, model_q.size() == 0});
    check("full", {31'd0, full}, {31'd0, model_q.size() == DEPTH});
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check("underflow", {31'd0, underflow}, {31'd0, m_udf});
`endif
  endtask

  // One clock of traffic: drive, update the model from pre-edge occupancy, compare.
  task automatic step(input logic c, input logic w, input logic r, input logic [31:0] d);
    bit was_full, was_empty;
    cs      = c;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    @(posedge clk);
    #1;
    if (c && r && !was_empty) m_dout = model_q.pop_front();
    if (c && w && !was_full) model_q.push_back(d);
    if (c && w && was_full) m_ovf = 1'b1;
    if (c && r && was_empty) m_udf = 1'b1;
    txn++;
    $display("txn %0d cs=%0b wr=%0b rd=%0b din=%0h -> dout=%0h empty=%0b full=%0b",
             txn, c, w, r, d, data_out, empty, full);
    check_model();
  endtask

  task automatic add_vec(input logic c, input logic w, input logic r, input logic [31:0] d,
                         input logic [31:0] dout, input logic e, input logic f);
    vec_t v;
    v.cs = c; v.wr = w; v.rd = r; v.din = d;
    v.dout = dout; v.empty = e; v.full = f;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] pw;
    rst_n   = 1'b0;
    cs      = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = 32'd0;
    model_reset();

    // Directed table: write 1,10,100 then read back; empty read; cs=0 pulses.
    add_vec(1, 1, 0, 32'd1,   32'd0,   0, 0);
    add_vec(1, 1, 0, 32'd10,  32'd0,   0, 0);
    add_vec(1, 1, 0, 32'd100, 32'd0,   0, 0);
    add_vec(1, 0, 1, 32'd0,   32'd1,   0, 0);
    add_vec(1, 0, 1, 32'd0,   32'd10,  0, 0);
    add_vec(1, 0, 1, 32'd0,   32'd100, 1, 0);
    add_vec(1, 0, 1, 32'd0,   32'd100, 1, 0);
    add_vec(0, 1, 0, 32'd55,  32'd100, 1, 0);
    add_vec(0, 1, 1, 32'd66,  32'd100, 1, 0);
    add_vec(0, 0, 1, 32'd0,   32'd100, 1, 0);
    for (int i = 0; i < 8; i++) begin
      pw = 32'd1 << i;
      add_vec(1, 1, 0, pw, (i == 0) ? 32'd100 : (pw >> 1), 0, 0);
      add_vec(1, 0, 1, 32'd0, pw, 1, 0);
    end

    #12;
    check("reset_empty", {31'd0, empty}, 32'd1);
    check("reset_full", {31'd0, full}, 32'd0);
    check("reset_dout", data_out, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].cs, vecs[i].wr, vecs[i].rd, vecs[i].din);
      check("vec_dout", data_out, vecs[i].dout);
      check("vec_empty", {31'd0, empty}, {31'd0, vecs[i].empty});
      check("vec_full", {31'd0, full}, {31'd0, vecs[i].full});
    end

    // Fill with 2**i for i=0..8; the ninth word must be dropped.
    for (int i = 0; i < 9; i++) begin
      step(1, 1, 0, 32'd1 << i);
      if (i == 7) check("full_after_8", {31'd0, full}, 32'd1);
    end
    check("full_after_9", {31'd0, full}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 1, 32'd0);
      check("drain_order", data_out, 32'd1 << i);
    end
    check("drain_empty", {31'd0, empty}, 32'd1);

    // Full with simultaneous read+write: read wins, write dropped.
    for (int i = 0; i < 8; i++) step(1, 1, 0, 32'h100 + i);
    step(1, 1, 1, 32'h999);
    check("full_rdwr_dout", data_out, 32'h100);
    check("full_rdwr_full", {31'd0, full}, 32'd0);
    for (int i = 0; i < 7; i++) step(1, 0, 1, 32'd0);
    check("full_rdwr_last", data_out, 32'h107);
    check("full_rdwr_empty", {31'd0, empty}, 32'd1);

    // Hold 4 entries, then 10 cycles of simultaneous read+write.
    for (int i = 0; i < 4; i++) step(1, 1, 0, 32'h200 + i);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 1, 32'h300 + i);
      check("steady_dout", data_out, (i < 4) ? 32'h200 + i : 32'h300 + i - 4);
      check("steady_occ", model_q.size(), 32'd4);
    end

    // Asynchronous reset between edges while partly full.
    step(1, 0, 1, 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_empty", {31'd0, empty}, 32'd1);
    check("async_rst_dout", data_out, 32'd0);
    check("async_rst_full", {31'd0, full}, 32'd0);
    #3;
    rst_n = 1'b1;
    step(1, 0, 1, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
